// File: rtl/memory_arbiter_pkg.sv
// Shared constants and types for the two-port memory arbiter.
package memory_arbiter_pkg;

  localparam int NUM_PORTS          = 2;
  localparam int DEFAULT_WIDTH      = 16;
  localparam int DEFAULT_ADDR_WIDTH = 16;

  // Identifies a requesting port; also used as the round-robin pointer value.
  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

  // One-hot grant vector for a single winning port.
  function automatic logic [NUM_PORTS-1:0] port_onehot(input port_e p);
    logic [NUM_PORTS-1:0] v;
    case (p)
      PORT0:   v = 2'b01;
      PORT1:   v = 2'b10;
      default: v = 2'b00;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/memory_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter. The pointer remembers the winner of the last
// contended cycle and only moves when both requests are present, so an
// uncontended grant never disturbs the fairness order.
module rr_arbiter2
  import memory_arbiter_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NUM_PORTS-1:0] req,
  output logic [NUM_PORTS-1:0] gnt
);

  port_e last_r;
  port_e winner_s;
  logic  contend_s;

  // Grant selection: lone requester wins, on contention the other port wins.
  always_comb begin
    contend_s = &req;
    winner_s  = PORT0;
    gnt       = 2'b00;
    if (contend_s) begin
      winner_s = (last_r == PORT0) ? PORT1 : PORT0;
      gnt      = port_onehot(winner_s);
    end else begin
      gnt = req;
    end
  end

  // Pointer register; reset leaves PORT1 as last winner so PORT0 is favoured.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_r <= PORT1;
    end else if (contend_s) begin
      last_r <= winner_s;
    end else begin
      last_r <= last_r;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Two-port front end for a single-write / single-read memory block. Reads and
// writes are arbitrated on separate channels; a read that targets the address
// being written in the same cycle is held off one cycle so it sees new data.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [WIDTH-1:0]      wdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [WIDTH-1:0]      wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [WIDTH-1:0]      rdata0,
  output logic [WIDTH-1:0]      rdata1,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_write_address,
  output logic [ADDR_WIDTH-1:0] mem_read_address,
  output logic [WIDTH-1:0]      mem_data_in,
  input  logic [WIDTH-1:0]      mem_data_out
);

  logic [NUM_PORTS-1:0] wr_req_s;
  logic [NUM_PORTS-1:0] rd_req_s;
  logic [NUM_PORTS-1:0] rd_req_eff_s;
  logic [NUM_PORTS-1:0] wr_gnt_raw_s;
  logic [NUM_PORTS-1:0] rd_gnt_raw_s;
  logic [NUM_PORTS-1:0] wr_gnt_s;
  logic [NUM_PORTS-1:0] rd_gnt_s;
  logic [NUM_PORTS-1:0] rvalid_r;

  // Split each port's single request line into a write or a read request.
  always_comb begin
    wr_req_s = {req1 & we1, req0 & we0};
    rd_req_s = {req1 & ~we1, req0 & ~we0};
  end

  rr_arbiter2 u_wr_arb (
    .clock   (clock),
    .reset_n (reset_n),
    .req     (wr_req_s),
    .gnt     (wr_gnt_raw_s)
  );

  // Write channel: gate grants with reset and steer the winner onto the bus.
  always_comb begin
    wr_gnt_s          = 2'b00;
    mem_write_enable  = 1'b0;
    mem_write_address = {ADDR_WIDTH{1'b0}};
    mem_data_in       = {WIDTH{1'b0}};
    if (reset_n) begin
      wr_gnt_s = wr_gnt_raw_s;
    end else begin
      wr_gnt_s = 2'b00;
    end
    case (wr_gnt_s)
      2'b01: begin
        mem_write_enable  = 1'b1;
        mem_write_address = addr0;
        mem_data_in       = wdata0;
      end
      2'b10: begin
        mem_write_enable  = 1'b1;
        mem_write_address = addr1;
        mem_data_in       = wdata1;
      end
      default: begin
        mem_write_enable  = 1'b0;
        mem_write_address = {ADDR_WIDTH{1'b0}};
        mem_data_in       = {WIDTH{1'b0}};
      end
    endcase
  end

  // Hold off any read whose address collides with this cycle's write.
  always_comb begin
    rd_req_eff_s[0] = rd_req_s[0] & ~(mem_write_enable & (addr0 == mem_write_address));
    rd_req_eff_s[1] = rd_req_s[1] & ~(mem_write_enable & (addr1 == mem_write_address));
  end

  rr_arbiter2 u_rd_arb (
    .clock   (clock),
    .reset_n (reset_n),
    .req     (rd_req_eff_s),
    .gnt     (rd_gnt_raw_s)
  );

  // Read channel: gate grants with reset and steer the winner's address.
  always_comb begin
    rd_gnt_s         = 2'b00;
    mem_read_address = {ADDR_WIDTH{1'b0}};
    if (reset_n) begin
      rd_gnt_s = rd_gnt_raw_s;
    end else begin
      rd_gnt_s = 2'b00;
    end
    case (rd_gnt_s)
      2'b01:   mem_read_address = addr0;
      2'b10:   mem_read_address = addr1;
      default: mem_read_address = {ADDR_WIDTH{1'b0}};
    endcase
  end

  // Owner tag of the read in flight; aligns with the memory's registered data.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rvalid_r <= 2'b00;
    end else begin
      rvalid_r <= rd_gnt_s;
    end
  end

  // Port-facing grant, valid and read-data outputs.
  always_comb begin
    gnt0    = wr_gnt_s[0] | rd_gnt_s[0];
    gnt1    = wr_gnt_s[1] | rd_gnt_s[1];
    rvalid0 = rvalid_r[0];
    rvalid1 = rvalid_r[1];
    rdata0  = mem_data_out;
    rdata1  = mem_data_out;
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed scenarios with literal expectations plus
// a randomized run, all checked every cycle against a behavioural model.
module tb_memory_arbiter;

  localparam int W  = 16;
  localparam int AW = 16;

  logic          clock;
  logic          reset_n;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [W-1:0]  wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [W-1:0]  rdata0, rdata1;
  logic          mem_write_enable;
  logic [AW-1:0] mem_write_address, mem_read_address;
  logic [W-1:0]  mem_data_in, mem_data_out;

  int checks = 0;
  int errors = 0;

  memory_arbiter #(.WIDTH(W), .ADDR_WIDTH(AW)) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .req0              (req0),
    .we0               (we0),
    .addr0             (addr0),
    .wdata0            (wdata0),
    .req1              (req1),
    .we1               (we1),
    .addr1             (addr1),
    .wdata1            (wdata1),
    .gnt0              (gnt0),
    .gnt1              (gnt1),
    .rvalid0           (rvalid0),
    .rvalid1           (rvalid1),
    .rdata0            (rdata0),
    .rdata1            (rdata1),
    .mem_write_enable  (mem_write_enable),
    .mem_write_address (mem_write_address),
    .mem_read_address  (mem_read_address),
    .mem_data_in       (mem_data_in),
    .mem_data_out      (mem_data_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Power-on contents of every memory word.
  function automatic logic [W-1:0] init_val(input logic [7:0] a);
    return {a, a} ^ 16'h5A5A;
  endfunction

  // Memory block driven by the DUT's buses (environment, not a checker).
  logic [W-1:0] env_mem  [256];
  bit           env_seen [256];
  always @(posedge clock) begin
    if (mem_write_enable) begin
      env_mem[mem_write_address[7:0]]  <= mem_data_in;
      env_seen[mem_write_address[7:0]] <= 1'b1;
    end
    mem_data_out <= env_seen[mem_read_address[7:0]] ? env_mem[mem_read_address[7:0]]
                                                     : init_val(mem_read_address[7:0]);
  end

  // ---------------- behavioural model ----------------
  // Winner among two requests: lone one wins, on a tie the one not favoured last.
  function automatic int rr_pick(input bit a, input bit b, input int last);
    if (a && b) return (last == 0) ? 1 : 0;
    if (a) return 0;
    if (b) return 1;
    return -1;
  endfunction

  int            m_wlast, m_rlast, m_wp, m_rp;
  bit            m_el0, m_el1, m_rv0, m_rv1;
  logic [AW-1:0] m_waddr, m_raddr;
  logic [W-1:0]  m_wdata, m_rdata;
  logic [W-1:0]  exp_mem  [256];
  bit            exp_seen [256];

  // Expected grants and bus values for the current inputs.
  always_comb begin
    m_wp = -1; m_rp = -1; m_el0 = 1'b0; m_el1 = 1'b0;
    m_waddr = '0; m_wdata = '0; m_raddr = '0;
    if (reset_n === 1'b1) begin
      m_wp = rr_pick(req0 && we0, req1 && we1, m_wlast);
      if (m_wp == 0) begin m_waddr = addr0; m_wdata = wdata0; end
      else if (m_wp == 1) begin m_waddr = addr1; m_wdata = wdata1; end
      m_el0 = req0 && !we0 && !(m_wp >= 0 && addr0 == m_waddr);
      m_el1 = req1 && !we1 && !(m_wp >= 0 && addr1 == m_waddr);
      m_rp  = rr_pick(m_el0, m_el1, m_rlast);
      if (m_rp == 0) m_raddr = addr0;
      else if (m_rp == 1) m_raddr = addr1;
    end
  end

  // Model state: fairness memory per channel, read owner, expected memory.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_wlast <= 1; m_rlast <= 1; m_rv0 <= 1'b0; m_rv1 <= 1'b0;
    end else begin
      if (req0 && we0 && req1 && we1) m_wlast <= m_wp;
      if (m_el0 && m_el1) m_rlast <= m_rp;
      m_rv0   <= (m_rp == 0);
      m_rv1   <= (m_rp == 1);
      m_rdata <= exp_seen[m_raddr[7:0]] ? exp_mem[m_raddr[7:0]] : init_val(m_raddr[7:0]);
      if (m_wp >= 0) begin
        exp_mem[m_waddr[7:0]]  <= m_wdata;
        exp_seen[m_waddr[7:0]] <= 1'b1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clock) begin
    #2;
    chk("gnt0", gnt0, (m_wp == 0) || (m_rp == 0));
    chk("gnt1", gnt1, (m_wp == 1) || (m_rp == 1));
    chk("mem_write_enable", mem_write_enable, m_wp >= 0);
    chk("mem_write_address", mem_write_address, m_waddr);
    chk("mem_data_in", mem_data_in, m_wdata);
    chk("mem_read_address", mem_read_address, m_raddr);
    chk("rvalid0", rvalid0, m_rv0);
    chk("rvalid1", rvalid1, m_rv1);
    if (m_rv0) chk("rdata0", rdata0, m_rdata);
    if (m_rv1) chk("rdata1", rdata1, m_rdata);
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [W-1:0] d0,
                       input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [W-1:0] d1);
    @(negedge clock);
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  bit            pr[2], pw[2], pg[2];
  logic [AW-1:0] pa[2];
  logic [W-1:0]  pd[2];

  initial begin
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clock);
    #3;
    chk("reset gnt0", gnt0, 1'b0);
    chk("reset rvalid0", rvalid0, 1'b0);
    chk("reset mem_write_enable", mem_write_enable, 1'b0);
    @(negedge clock); reset_n = 1'b1;

    // Port 0 writes then reads back.
    drive(1'b1, 1'b1, 16'h0003, 16'h1111, 1'b0, 1'b0, 16'h0000, 16'h0000);
    #3; chk("wr gnt0", gnt0, 1'b1); chk("wr addr", mem_write_address, 16'h0003);
    chk("wr data", mem_data_in, 16'h1111);
    drive(1'b1, 1'b0, 16'h0003, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
    #3; chk("rd gnt0", gnt0, 1'b1); chk("rd addr", mem_read_address, 16'h0003);
    idle();
    #3; chk("rb rvalid0", rvalid0, 1'b1); chk("rb rdata0", rdata0, 16'h1111);
    chk("rb rvalid1", rvalid1, 1'b0);

    // Both ports read every cycle: grants alternate starting with port 0.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0002, 16'h0000);
      #3;
      chk("alt gnt0", gnt0, (i % 2) == 0);
      chk("alt gnt1", gnt1, (i % 2) == 1);
      if (i > 0) begin
        chk("alt rvalid0", rvalid0, ((i - 1) % 2) == 0);
        chk("alt rdata", rdata0, (((i - 1) % 2) == 0) ? 16'h5A5A : 16'h5858);
      end
    end
    idle();
    #3; chk("alt last rvalid1", rvalid1, 1'b1); chk("alt last rdata1", rdata1, 16'h5858);

    // Same-address write and read: read withheld one cycle, returns new data.
    drive(1'b1, 1'b0, 16'h0003, 16'h0000, 1'b1, 1'b1, 16'h0003, 16'hAAAA);
    #3; chk("haz gnt1", gnt1, 1'b1); chk("haz gnt0", gnt0, 1'b0);
    drive(1'b1, 1'b0, 16'h0003, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
    #3; chk("haz late gnt0", gnt0, 1'b1);
    idle();
    #3; chk("haz rvalid0", rvalid0, 1'b1); chk("haz rdata0", rdata0, 16'hAAAA);

    // Different-address write and read proceed together.
    drive(1'b1, 1'b1, 16'h0004, 16'h5555, 1'b1, 1'b0, 16'h0002, 16'h0000);
    #3; chk("conc gnt0", gnt0, 1'b1); chk("conc gnt1", gnt1, 1'b1);
    chk("conc we", mem_write_enable, 1'b1); chk("conc raddr", mem_read_address, 16'h0002);
    idle();
    #3; chk("conc rvalid1", rvalid1, 1'b1); chk("conc rdata1", rdata1, 16'h5858);
    chk("conc rvalid0", rvalid0, 1'b0);

    // Idle cycles: buses quiet, no valid.
    for (int i = 0; i < 3; i++) begin
      idle();
      #3;
      chk("idle we", mem_write_enable, 1'b0);
      chk("idle waddr", mem_write_address, 16'h0000);
      chk("idle raddr", mem_read_address, 16'h0000);
      chk("idle rvalid0", rvalid0, 1'b0);
      chk("idle rvalid1", rvalid1, 1'b0);
    end

    // Reset right after a read grant cancels the valid and re-favours port 0.
    drive(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0002, 16'h0000);
    #3; chk("rst pre gnt0", gnt0, 1'b1);
    @(posedge clock); #1 reset_n = 1'b0;
    #2; chk("rst rvalid0", rvalid0, 1'b0); chk("rst rvalid1", rvalid1, 1'b0);
    chk("rst gnt0", gnt0, 1'b0); chk("rst gnt1", gnt1, 1'b0);
    @(negedge clock); reset_n = 1'b1;
    #3; chk("post rst gnt0", gnt0, 1'b1); chk("post rst gnt1", gnt1, 1'b0);
    idle();

    // Randomized traffic; requests are held until granted, occasionally dropped.
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!(pr[p] && !pg[p] && $urandom_range(15) != 0)) begin
          pr[p] = ($urandom_range(3) != 0);
          pw[p] = ($urandom_range(1) == 1);
          pa[p] = 16'($urandom_range(7));
          if ($urandom_range(3) == 0) pa[p][15] = 1'b1;
          pd[p] = 16'($urandom);
        end
      end
      drive(pr[0], pw[0], pa[0], pd[0], pr[1], pw[1], pa[1], pd[1]);
      #3;
      pg[0] = (m_wp == 0) || (m_rp == 0);
      pg[1] = (m_wp == 1) || (m_rp == 1);
    end
    idle();
    idle();
    #3;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter WIDTH, default 16, data word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 16, word address width in bits.
REQ-003 clock  input  1  Sole clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  Reset; asynchronous, active-low.
REQ-005 reqN  input  1  Port N access request (N = 0, 1); held with its qualifiers until grant.
REQ-006 weN  input  1  Port N access type: 1 = write, 0 = read.
REQ-007 addrN  input  ADDR_WIDTH  Port N word address.
REQ-008 wdataN  input  WIDTH  Port N write data.
REQ-009 gntN  output  1  Port N access accepted this cycle; combinational.
REQ-010 rvalidN  output  1  Port N read data valid; registered.
REQ-011 rdataN  output  WIDTH  Port N read data; passthrough of mem_data_out.
REQ-012 mem_write_enable  output  1  Write strobe to memory_block.
REQ-013 mem_write_address, mem_read_address  output  ADDR_WIDTH  Memory address buses.
REQ-014 mem_data_in  output  WIDTH  Memory write data.
REQ-015 mem_data_out  input  WIDTH  Memory registered read data, valid the cycle after its read edge.

Function
- REQ-016 Read and write channels SHALL be arbitrated independently: at most one read grant and one write grant per cycle.
- REQ-017 Each channel SHALL use 2-way round-robin: on contention, the port not granted last on that channel wins; the pointer updates only on a contended grant.
- REQ-018 Uncontended requests SHALL be granted in the cycle presented; a granted access takes effect at the next rising edge.
- REQ-019 When a write and a read are granted in the same cycle to equal addresses, the read SHALL be withheld (gnt low) and granted no earlier than the next cycle, so it returns the new data.
- REQ-020 A port requesting read and write in different cycles SHALL be served in request order; a port never receives two grants in one cycle.
- REQ-021 A read granted at edge K SHALL assert rvalidN for exactly one cycle after edge K, with rdataN = mem_data_out; rvalid of the non-owner SHALL be 0.
- REQ-022 Back-to-back reads SHALL sustain one read per cycle with 1-cycle latency, the owner tag pipelined one stage.
- REQ-023 With no write grant, mem_write_enable SHALL be 0, mem_write_address and mem_data_in 0; with no read grant, mem_read_address SHALL be 0 and no rvalid follows.
- REQ-024 A request dropped before grant SHALL be discarded without memory side effect.
- REQ-025 Address width arithmetic SHALL be pure passthrough; no wrap or offset applied.

Reset
- REQ-026 While reset_n is low: gnt0/gnt1 = 0, rvalid0/rvalid1 = 0, mem_write_enable = 0, all memory address/data outputs = 0.
- REQ-027 Reset SHALL set both round-robin pointers to favour port 0.
- REQ-028 Reset asserted mid-read SHALL cancel the pending rvalid; memory contents are not altered by reset.

Structure
- REQ-029 Shared package memory_arbiter_pkg SHALL hold the port-count constant (2) and the default WIDTH/ADDR_WIDTH constants.
- REQ-030 A sub-module rr_arbiter2 (2 requests, 2 grants, pointer register, async active-low reset) SHALL be instantiated once per channel.

Verification
- REQ-031 Port 0 writes 0x1111 to 0x0003, then reads 0x0003 -> gnt0 each cycle, rvalid0 one cycle after read grant, rdata0 = 0x1111.
- REQ-032 Both ports read (0x0000, 0x0002) every cycle for 4 cycles -> grants alternate 0,1,0,1; rvalids alternate matching; port 1 data from 0x0002.
- REQ-033 Same cycle: port 1 writes 0xAAAA to 0x0003, port 0 reads 0x0003 -> gnt1 only, gnt0 next cycle, rdata0 = 0xAAAA.
- REQ-034 Same cycle: port 0 writes 0x5555 to 0x0004, port 1 reads 0x0002 -> both granted, write and read proceed concurrently.
- REQ-035 reset_n low between read grant and data edge -> rvalid0/rvalid1 stay 0; after release, a contended read grants port 0 first.
- REQ-036 No requests for 3 cycles -> mem_write_enable 0, both addresses 0, no rvalid.
